store_lane_unit: RTL and testbench

- Write-side counterpart of the load-path sign-extension logic: narrows a 32-bit register value to a byte/halfword/word store, places it on the correct little-endian byte lanes, generates byte enables and runs a request/acknowledge handshake with data memory.
- Sits between the CPU datapath (store instructions) and the data-memory port.
- Detects misaligned or invalid-size stores and memory timeouts; reports completion or error to the control unit.

---
 rtl/store_lane_unit.sv | 173 +++++++++++++++++
 tb/tb_store_lane_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_lane_unit.sv
// ---------------------------------------------------------------------------
// store_lane_unit
//
// Purpose:
//   Write-side companion to the load-path sign extender. Takes a 32-bit
//   register value and a store size from the CPU datapath, places the
//   narrowed data on the correct little-endian byte lanes, generates byte
//   enables and drives a request/acknowledge write to data memory.
//   Misaligned stores, invalid sizes and memory timeouts are reported as a
//   one-cycle err pulse with a sticky err_code.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   start      in   1   one-cycle store request, honoured in IDLE only
//   size       in   2   00 byte, 01 halfword, 10 word, 11 invalid
//   addr       in  32   byte address of the store
//   wdata      in  32   source register value (low byte/half for narrow stores)
//   mem_ack    in   1   memory accepted the write, honoured in REQ only
//   mem_we     out  1   write request, held high for the whole REQ phase
//   mem_addr   out 32   word-aligned address {addr[31:2], 2'b00}
//   mem_wdata  out 32   lane-placed write data
//   mem_be     out  4   byte enables, bit i selects bits 8i+7:8i
//   busy       out  1   high while a request is outstanding
//   done       out  1   one-cycle pulse on a successful store
//   err        out  1   one-cycle pulse on any error
//   err_code   out  2   00 none, 01 misaligned, 10 invalid size, 11 timeout
// ---------------------------------------------------------------------------
module store_lane_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FIN,
        FAIL
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [31:0] lane_wdata;
    logic [3:0]  lane_be;
    logic        misaligned;

    // Lane placement straight from the request inputs so that the registered
    // memory outputs are valid in the cycle right after start. Narrow data is
    // replicated across all lanes; only the byte enables pick the real lanes.
    always_comb begin
        lane_wdata = wdata;
        lane_be    = 4'b1111;
        case (size)
            2'b00: begin
                lane_wdata = {4{wdata[7:0]}};
                lane_be    = 4'b0001 << addr[1:0];
            end
            2'b01: begin
                lane_wdata = {2{wdata[15:0]}};
                lane_be    = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                lane_wdata = wdata;
                lane_be    = 4'b1111;
            end
        endcase
    end

    // A halfword must sit on an even address and a word on a multiple of four.
    assign misaligned = ((size == 2'b01) && addr[0]) ||
                        ((size == 2'b10) && (addr[1:0] != 2'b00));

    // Single control FSM with all outputs registered. The done/err pulses are
    // raised on the edge entering FIN/FAIL and dropped on the edge leaving, so
    // each lasts exactly one cycle. An ack in the same cycle the counter hits
    // its limit is treated as success, since the memory did take the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    err    <= 1'b0;
                    mem_we <= 1'b0;
                    busy   <= 1'b0;
                    mem_be <= 4'b0000;
                    cnt    <= '0;
                    if (start) begin
                        err_code  <= 2'b00;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wdata <= lane_wdata;
                        // Invalid size takes priority over alignment.
                        if (size == 2'b11) begin
                            err_code <= 2'b10;
                            err      <= 1'b1;
                            state    <= FAIL;
                        end else if (misaligned) begin
                            err_code <= 2'b01;
                            err      <= 1'b1;
                            state    <= FAIL;
                        end else begin
                            mem_we <= 1'b1;
                            busy   <= 1'b1;
                            mem_be <= lane_be;
                            state  <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (mem_ack) begin
                        mem_we <= 1'b0;
                        busy   <= 1'b0;
                        mem_be <= 4'b0000;
                        done   <= 1'b1;
                        state  <= FIN;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        mem_we   <= 1'b0;
                        busy     <= 1'b0;
                        mem_be   <= 4'b0000;
                        err      <= 1'b1;
                        err_code <= 2'b11;
                        state    <= FAIL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                FAIL: begin
                    err   <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_lane_unit.sv
// ---------------------------------------------------------------------------
// tb_store_lane_unit
//
// Directed bench for store_lane_unit. The stimulus process pushes the
// expected outcome of every store into a queue before issuing it; an
// independent monitor watches the memory port and pops/compares whenever a
// done or err pulse appears.
// ---------------------------------------------------------------------------
module tb_store_lane_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_ack;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    typedef struct {
        logic        is_err;
        logic [1:0]  code;
        int          we_cycles;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;

    int          we_cnt   = 0;
    int          busy_cnt = 0;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_be;

    store_lane_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .mem_ack   (mem_ack),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic is_err, input logic [1:0] code, input int we_cycles,
                            input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        e.is_err    = is_err;
        e.code      = code;
        e.we_cycles = we_cycles;
        e.addr      = a;
        e.wdata     = d;
        e.be        = be;
        exp_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, accumulates what the memory port
    // showed during the request and settles it against the queue head when
    // the transaction ends.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                we_cnt   = 0;
                busy_cnt = 0;
            end else begin
                if (mem_we) begin
                    we_cnt++;
                    cap_addr  = mem_addr;
                    cap_wdata = mem_wdata;
                    cap_be    = mem_be;
                end
                if (busy) busy_cnt++;
                if (done || err) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_result", {30'd0, err, done}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("result_is_err", {31'd0, err}, {31'd0, e.is_err});
                        check_output("result_is_done", {31'd0, done}, {31'd0, ~e.is_err});
                        check_output("err_code", {30'd0, err_code}, {30'd0, e.code});
                        check_output("we_cycles", we_cnt, e.we_cycles);
                        check_output("busy_cycles", busy_cnt, e.we_cycles);
                        check_output("we_low_at_end", {31'd0, mem_we}, 32'd0);
                        check_output("be_zero_at_end", {28'd0, mem_be}, 32'd0);
                        if (!e.is_err) begin
                            check_output("mem_addr", cap_addr, e.addr);
                            check_output("mem_wdata", cap_wdata, e.wdata);
                            check_output("mem_be", {28'd0, cap_be}, {28'd0, e.be});
                        end
                    end
                    we_cnt   = 0;
                    busy_cnt = 0;
                end
            end
        end
    end

    // Issues one store. ack_cycle selects the mem_we cycle (1-based) in which
    // mem_ack is raised; 0 means never acknowledge. Returns once the unit is
    // back in IDLE, or after a bounded wait that counts as a failure.
    task automatic apply_stimulus(input logic [1:0] s, input logic [31:0] a,
                                  input logic [31:0] d, input int ack_cycle);
        bit seen;
        @(posedge clk); #1;
        start = 1'b1;
        size  = s;
        addr  = a;
        wdata = d;
        @(posedge clk); #1;
        start = 1'b0;
        if (ack_cycle > 0) begin
            repeat (ack_cycle - 1) @(posedge clk);
            #1;
            mem_ack = 1'b1;
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done || err) seen = 1'b1;
        end
        check_output("completion_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        size    = 2'b00;
        addr    = 32'd0;
        wdata   = 32'd0;
        mem_ack = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_output("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_output("rst_mem_addr", mem_addr, 32'd0);
        check_output("rst_mem_wdata", mem_wdata, 32'd0);
        check_output("rst_mem_be", {28'd0, mem_be}, 32'd0);
        check_output("rst_flags", {28'd0, busy, done, err, 1'b0}, 32'd0);
        check_output("rst_err_code", {30'd0, err_code}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Successful stores, lane placement
        push_exp(1'b0, 2'b00, 1, 32'h0000_1000, 32'hABAB_ABAB, 4'b1000);
        apply_stimulus(2'b00, 32'h0000_1003, 32'h1234_56AB, 1);
        push_exp(1'b0, 2'b00, 1, 32'h0000_1000, 32'hBEEF_BEEF, 4'b0011);
        apply_stimulus(2'b01, 32'h0000_1000, 32'hFFFF_BEEF, 1);
        push_exp(1'b0, 2'b00, 1, 32'h0000_1000, 32'hBEEF_BEEF, 4'b1100);
        apply_stimulus(2'b01, 32'h0000_1002, 32'hFFFF_BEEF, 1);
        push_exp(1'b0, 2'b00, 1, 32'h0000_2000, 32'hCAFE_F00D, 4'b1111);
        apply_stimulus(2'b10, 32'h0000_2000, 32'hCAFE_F00D, 1);
        push_exp(1'b0, 2'b00, 2, 32'h0000_1000, 32'h7777_7777, 4'b0010);
        apply_stimulus(2'b00, 32'h0000_1001, 32'hDEAD_0077, 2);

        // Misaligned and invalid size: no write ever issued
        push_exp(1'b1, 2'b01, 0, 32'd0, 32'd0, 4'd0);
        apply_stimulus(2'b01, 32'h0000_1001, 32'h0000_1111, 0);
        push_exp(1'b1, 2'b01, 0, 32'd0, 32'd0, 4'd0);
        apply_stimulus(2'b10, 32'h0000_1002, 32'h2222_2222, 0);
        push_exp(1'b1, 2'b10, 0, 32'd0, 32'd0, 4'd0);
        apply_stimulus(2'b11, 32'h0000_1001, 32'h3333_3333, 0);

        // Timeout, then ack in the last allowed cycle
        push_exp(1'b1, 2'b11, 16, 32'd0, 32'd0, 4'd0);
        apply_stimulus(2'b10, 32'h0000_4000, 32'h4444_4444, 0);
        repeat (3) @(negedge clk);
        check_output("err_code_held", {30'd0, err_code}, 32'd3);
        push_exp(1'b0, 2'b00, 16, 32'h0000_4000, 32'h5555_5555, 4'b1111);
        apply_stimulus(2'b10, 32'h0000_4000, 32'h5555_5555, 16);

        // Protocol abuse: start in REQ and FIN, mem_ack in IDLE
        push_exp(1'b0, 2'b00, 3, 32'h0000_3000, 32'h1122_3344, 4'b1111);
        @(posedge clk); #1;
        start = 1'b1; size = 2'b10; addr = 32'h0000_3000; wdata = 32'h1122_3344;
        @(posedge clk); #1;
        start = 1'b1; size = 2'b11; addr = 32'h0000_5001; wdata = 32'h9999_9999;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        start = 1'b1; size = 2'b00; addr = 32'h0000_6000; wdata = 32'h0000_00AA;
        @(posedge clk); #1;
        start = 1'b0;
        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_ack = 1'b0;
        repeat (20) @(negedge clk);
        check_output("abuse_no_we", we_cnt, 0);
        check_output("abuse_queue_empty", exp_q.size(), 0);
        check_output("abuse_err_code", {30'd0, err_code}, 32'd0);

        // Reset in the third wait cycle of REQ
        @(posedge clk); #1;
        start = 1'b1; size = 2'b00; addr = 32'h0000_0042; wdata = 32'h0000_005A;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        check_output("pre_rst_mem_we", {31'd0, mem_we}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_output("async_rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_output("async_rst_busy", {31'd0, busy}, 32'd0);
        check_output("async_rst_mem_be", {28'd0, mem_be}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        push_exp(1'b0, 2'b00, 1, 32'h0000_0040, 32'h5A5A_5A5A, 4'b0100);
        apply_stimulus(2'b00, 32'h0000_0042, 32'h0000_005A, 1);

        repeat (3) @(negedge clk);
        check_output("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
